fir_mac_accum: RTL and testbench

//  Datapath stage directly downstream of the FIR tap controller. Holds the NTAPS-deep

---
 rtl/fir_mac_accum.sv | 151 +++++++++++++++
 tb/tb_fir_mac_accum.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_accum.sv
// MAC datapath for a FIR filter: NTAPS-deep sample delay line, pipelined multiply/accumulate
// driven beat-by-beat by an external tap controller, saturated/shifted result with a 1-cycle strobe.
module fir_mac_accum #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int NTAPS  = 12,
   parameter int ACC_W  = 36,
   parameter int SHIFT  = 0,
   parameter int OUT_W  = 16
) (
   input  logic                     clk,
   input  logic                     GlobalReset_n,
   input  logic                     srdyi,
   input  logic signed [DATA_W-1:0] din,
   input  logic        [3:0]        coeff_sel,
   input  logic signed [COEF_W-1:0] coeff_in,
   input  logic                     sum_en,
   input  logic                     sum_rst,
   output logic signed [OUT_W-1:0]  dout,
   output logic                     srdyo,
   output logic                     overrun
);

   localparam int PROD_W = DATA_W + COEF_W;
   localparam int IDX_W  = (NTAPS > 1) ? $clog2(NTAPS) : 1;
   localparam logic [4:0] NTAPS_L = 5'(NTAPS);
   localparam logic [4:0] LAST_L  = 5'(NTAPS - 1);
   localparam logic signed [ACC_W-1:0] OUT_MAX =
      $signed({{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
   localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

   typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_e;

   state_e                    state_q, state_d;
   logic signed [DATA_W-1:0]  tap_q [NTAPS];
   logic signed [DATA_W-1:0]  tap_d [NTAPS];
   logic signed [PROD_W-1:0]  prod_q, prod_d;
   logic                      prod_vld_q, prod_vld_d;
   logic                      last_q, last_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic signed [OUT_W-1:0]   dout_q, dout_d;
   logic                      srdyo_q, srdyo_d;
   logic                      overrun_q, overrun_d;

   logic                      sel_ok;
   logic [IDX_W-1:0]          sel_idx;
   logic signed [DATA_W-1:0]  tap_sel;
   logic signed [PROD_W-1:0]  prod_full;
   logic signed [ACC_W-1:0]   acc_sum;

   function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
      logic signed [ACC_W-1:0] s;
      s = v >>> SHIFT;
      if (s > OUT_MAX)      sat_out = OUT_MAX[OUT_W-1:0];
      else if (s < OUT_MIN) sat_out = OUT_MIN[OUT_W-1:0];
      else                  sat_out = s[OUT_W-1:0];
   endfunction

   always_comb begin
      sel_ok    = ({1'b0, coeff_sel} < NTAPS_L);
      sel_idx   = IDX_W'(coeff_sel);
      tap_sel   = sel_ok ? tap_q[sel_idx] : '0;
      prod_full = tap_sel * coeff_in;
      acc_sum   = acc_q + $signed({{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q});
   end

   always_comb begin
      state_d    = state_q;
      tap_d      = tap_q;
      prod_d     = prod_q;
      prod_vld_d = 1'b0;
      last_d     = last_q;
      acc_d      = acc_q;
      dout_d     = dout_q;
      srdyo_d    = 1'b0;
      overrun_d  = overrun_q;

      case (state_q)
         IDLE: begin
            if (srdyi) begin
               for (int i = NTAPS-1; i > 0; i--) tap_d[i] = tap_q[i-1];
               tap_d[0] = din;
               acc_d    = '0;
               state_d  = ACCUM;
            end
         end
         ACCUM: begin
            if (srdyi) overrun_d = 1'b1;
            // Stage 1: product of the beat sampled this edge; stage 2: accumulate previous one.
            if (sum_en) begin
               prod_d     = prod_full;
               prod_vld_d = 1'b1;
               last_d     = ({1'b0, coeff_sel} == LAST_L);
            end
            if (prod_vld_q) begin
               acc_d = acc_sum;
               if (last_q) begin
                  dout_d     = sat_out(acc_sum);
                  srdyo_d    = 1'b1;
                  prod_vld_d = 1'b0;
                  state_d    = OUT;
               end
            end
         end
         OUT: begin
            if (srdyi) overrun_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Abort wins over everything except the sticky overrun flag; delay line survives.
      if (sum_rst) begin
         tap_d      = tap_q;
         acc_d      = '0;
         prod_vld_d = 1'b0;
         srdyo_d    = 1'b0;
         dout_d     = dout_q;
         state_d    = IDLE;
      end
   end

   always_ff @(posedge clk or negedge GlobalReset_n) begin
      if (!GlobalReset_n) begin
         state_q    <= IDLE;
         for (int i = 0; i < NTAPS; i++) tap_q[i] <= '0;
         prod_q     <= '0;
         prod_vld_q <= 1'b0;
         last_q     <= 1'b0;
         acc_q      <= '0;
         dout_q     <= '0;
         srdyo_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tap_q      <= tap_d;
         prod_q     <= prod_d;
         prod_vld_q <= prod_vld_d;
         last_q     <= last_d;
         acc_q      <= acc_d;
         dout_q     <= dout_d;
         srdyo_q    <= srdyo_d;
         overrun_q  <= overrun_d;
      end
   end

   assign dout    = dout_q;
   assign srdyo   = srdyo_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_fir_mac_accum.sv
// Directed bench for fir_mac_accum: one task per scenario, hand-computed expected results.
module tb_fir_mac_accum;

   logic               clk = 1'b0;
   logic               GlobalReset_n = 1'b0;
   logic               srdyi = 1'b0;
   logic signed [15:0] din = '0;
   logic        [3:0]  coeff_sel = '0;
   logic signed [15:0] coeff_in = '0;
   logic               sum_en = 1'b0;
   logic               sum_rst = 1'b0;
   logic signed [15:0] dout;
   logic               srdyo;
   logic               overrun;

   int checks = 0;
   int fails  = 0;
   int pulse_cnt = 0;

   fir_mac_accum dut (
      .clk(clk), .GlobalReset_n(GlobalReset_n), .srdyi(srdyi), .din(din),
      .coeff_sel(coeff_sel), .coeff_in(coeff_in), .sum_en(sum_en), .sum_rst(sum_rst),
      .dout(dout), .srdyo(srdyo), .overrun(overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (srdyo === 1'b1) pulse_cnt++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_sample(input int d);
      din = 16'(d); srdyi = 1'b1;
      tick();
      srdyi = 1'b0;
   endtask

   task automatic beat(input int sel, input int coef);
      coeff_sel = 4'(sel); coeff_in = 16'(coef); sum_en = 1'b1;
      tick();
      sum_en = 1'b0;
   endtask

   task automatic abort_tick();
      sum_rst = 1'b1;
      tick();
      sum_rst = 1'b0;
   endtask

   // Leaves samples 1..12 in the delay line (tap0 = 12) with the FSM in ACCUM.
   task automatic load12();
      for (int v = 1; v <= 12; v++) begin
         push_sample(v);
         if (v < 12) abort_tick();
      end
   endtask

   task automatic wait_srdyo(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         if (srdyo === 1'b1) seen = 1'b1;
         else tick();
      end
      tick();
   endtask

   task automatic test_reset();
      GlobalReset_n = 1'b0;
      tick(); tick();
      GlobalReset_n = 1'b1;
      tick();
      checks++; if (dout !== 16'sd0) begin fails++; $display("FAIL reset_dout got %0d want 0", dout); end
      checks++; if (srdyo !== 1'b0) begin fails++; $display("FAIL reset_srdyo got %b want 0", srdyo); end
      checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b want 0", overrun); end
   endtask

   task automatic test_basic_latency();
      int p0;
      p0 = pulse_cnt;
      push_sample(2);
      for (int s = 0; s < 12; s++) beat(s, (s == 0) ? 3 : 0);
      checks++; if (srdyo !== 1'b0) begin fails++; $display("FAIL lat_early srdyo got %b want 0", srdyo); end
      tick();
      checks++; if (srdyo !== 1'b1) begin fails++; $display("FAIL lat_strobe srdyo got %b want 1", srdyo); end
      checks++; if (dout !== 16'sd6) begin fails++; $display("FAIL basic_dout got %0d want 6", dout); end
      tick();
      checks++; if (srdyo !== 1'b0) begin fails++; $display("FAIL lat_pulse_width srdyo got %b want 0", srdyo); end
      checks++; if (dout !== 16'sd6) begin fails++; $display("FAIL basic_hold got %0d want 6", dout); end
      checks++; if (pulse_cnt - p0 !== 1) begin fails++; $display("FAIL basic_pulses got %0d want 1", pulse_cnt - p0); end
   endtask

   task automatic test_sum_gaps();
      bit seen;
      load12();
      for (int s = 0; s < 12; s++) beat(s, 1);
      wait_srdyo(seen);
      checks++; if (!seen || dout !== 16'sd78) begin fails++; $display("FAIL sum78 got %0d seen %b want 78", dout, seen); end
      load12();
      for (int s = 0; s < 12; s++) begin
         if (s == 11) beat(14, 100);
         beat(s, 1);
         if (s % 3 == 1) begin tick(); tick(); end
      end
      wait_srdyo(seen);
      checks++; if (!seen || dout !== 16'sd78) begin fails++; $display("FAIL sum78_gaps got %0d seen %b want 78", dout, seen); end
   endtask

   task automatic test_saturation();
      bit seen;
      logic signed [15:0] exp;
      push_sample(32767);
      beat(0, 32767); beat(0, 32767);
      for (int s = 1; s < 12; s++) beat(s, 0);
      wait_srdyo(seen);
      exp = 16'sd32767;
      checks++; if (!seen || dout !== exp) begin fails++; $display("FAIL sat_pos got %0d want %0d", dout, exp); end
      push_sample(-32768);
      beat(0, 32767); beat(0, 32767);
      for (int s = 1; s < 12; s++) beat(s, 0);
      wait_srdyo(seen);
      exp = -16'sd32768;
      checks++; if (!seen || dout !== exp) begin fails++; $display("FAIL sat_neg got %0d want %0d", dout, exp); end
   endtask

   task automatic test_reset_mid();
      bit seen;
      int p0;
      push_sample(9);
      for (int s = 0; s < 5; s++) beat(s, 1);
      GlobalReset_n = 1'b0;
      #2;
      checks++; if (dout !== 16'sd0 || srdyo !== 1'b0 || overrun !== 1'b0) begin
         fails++; $display("FAIL midreset_outs got dout %0d srdyo %b ovr %b want 0 0 0", dout, srdyo, overrun); end
      tick();
      GlobalReset_n = 1'b1;
      tick();
      p0 = pulse_cnt;
      for (int s = 0; s < 12; s++) beat(s, 1);
      tick(); tick(); tick();
      checks++; if (pulse_cnt - p0 !== 0) begin fails++; $display("FAIL midreset_idle_beats pulses got %0d want 0", pulse_cnt - p0); end
      push_sample(5);
      for (int s = 0; s < 12; s++) beat(s, (s == 0) ? 2 : 0);
      wait_srdyo(seen);
      checks++; if (!seen || dout !== 16'sd10) begin fails++; $display("FAIL midreset_fresh got %0d want 10", dout); end
   endtask

   task automatic test_overrun();
      bit seen;
      checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_pre got %b want 0", overrun); end
      load12();
      for (int s = 0; s < 12; s++) beat(s, s + 1);
      wait_srdyo(seen);
      checks++; if (!seen || dout !== 16'sd364) begin fails++; $display("FAIL ovr_ref got %0d want 364", dout); end
      load12();
      for (int s = 0; s < 12; s++) begin
         if (s == 6) begin din = 16'sd999; srdyi = 1'b1; end
         beat(s, s + 1);
         srdyi = 1'b0;
      end
      wait_srdyo(seen);
      checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag got %b want 1", overrun); end
      checks++; if (!seen || dout !== 16'sd364) begin fails++; $display("FAIL ovr_result got %0d want 364", dout); end
   endtask

   task automatic test_abort();
      bit seen;
      int p0;
      p0 = pulse_cnt;
      push_sample(3);
      for (int s = 0; s < 7; s++) beat(s, 1);
      sum_rst = 1'b1;
      beat(7, 1);
      sum_rst = 1'b0;
      for (int s = 8; s < 12; s++) beat(s, 1);
      for (int i = 0; i < 5; i++) tick();
      checks++; if (pulse_cnt - p0 !== 0) begin fails++; $display("FAIL abort_nostrobe pulses got %0d want 0", pulse_cnt - p0); end
      checks++; if (dout !== 16'sd364) begin fails++; $display("FAIL abort_dout_kept got %0d want 364", dout); end
      push_sample(7);
      for (int s = 0; s < 12; s++) beat(s, (s == 0) ? 4 : 0);
      wait_srdyo(seen);
      checks++; if (!seen || dout !== 16'sd28) begin fails++; $display("FAIL abort_fresh got %0d want 28", dout); end
   endtask

   initial begin
      test_reset();
      test_basic_latency();
      test_sum_gaps();
      test_saturation();
      test_reset_mid();
      test_overrun();
      test_abort();
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
